seg_scan_6d: RTL and testbench

SEG_SCAN_6D -- requirements
Module: seg_scan_6d

---
 rtl/seg_scan_6d.sv | 125 ++++++++++++
 tb/tb_seg_scan_6d.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_6d.sv
// Six-digit multiplexed 7-segment scanner with tear-free value update at frame boundaries.
// Latency: an/seg/dp are registered one cycle after index/display; no backpressure (load always accepted).
module seg_scan_6d #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] bcd_in,
  input  logic        load,
  input  logic [5:0]  dp_mask,
  input  logic        blank_lz,
  output logic [5:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done,
  output logic        pending
);

  typedef struct packed {
    logic [23:0] bcd;
    logic [5:0]  dpm;
    logic        blz;
  } disp_t;

  localparam logic [19:0] DIV_MAX = 20'(SCAN_DIV - 1);

  logic [19:0] cnt;
  logic [2:0]  idx;
  disp_t       disp;
  disp_t       shadow;
  disp_t       in_val;
  logic        tick;
  logic        wrap;
  logic [5:0]  zero_run;
  logic        run;
  logic [3:0]  cur_nib;
  logic        blank;

  assign in_val = {bcd_in, dp_mask, blank_lz};
  assign tick   = (cnt == DIV_MAX);
  assign wrap   = tick && (idx == 3'd5);

  function automatic logic [6:0] enc7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // zero_run[k] is set when digit k and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    zero_run = 6'b0;
    run      = 1'b1;
    for (int k = 5; k >= 1; k--) begin
      run         = run & (disp.bcd[k*4 +: 4] == 4'd0);
      zero_run[k] = run;
    end
  end

  assign cur_nib = disp.bcd[{idx, 2'b00} +: 4];
  assign blank   = disp.blz && zero_run[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      if (tick) begin
        cnt <= '0;
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

  // A load landing on the wrap cycle goes straight to the display and never raises pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp    <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      if (load)
        shadow <= in_val;
      if (load && wrap) begin
        disp    <= in_val;
        pending <= 1'b0;
      end else begin
        if (wrap && pending) begin
          disp    <= shadow;
          pending <= 1'b0;
        end
        if (load)
          pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= 6'h3F;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= ~(6'd1 << idx);
      seg        <= blank ? 7'h7F : enc7(cur_nib);
      dp         <= ~disp.dpm[idx];
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_6d.sv
// Randomised and directed bench for seg_scan_6d against a frame/slot arithmetic model.
module tb_seg_scan_6d;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] bcd_in = '0;
  logic        load = 1'b0;
  logic [5:0]  dp_mask = '0;
  logic        blank_lz = 1'b0;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;
  logic        pending;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  seg_scan_6d #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done),
    .pending(pending)
  );

  always #5 clk = ~clk;

  logic [6:0] enc [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  // Model: cycle m_t since reset; slot = (m_t/4)%6, wrap when m_t%24 == 23.
  logic [23:0] m_bcd_d, m_bcd_s;
  logic [5:0]  m_dpm_d, m_dpm_s;
  logic        m_blz_d, m_blz_s, m_pend;
  int          m_t;
  logic [5:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fd;

  function automatic logic [6:0] model_seg(input logic [23:0] b, input logic blz, input int s);
    logic [23:0] upper;
    logic [23:0] nib;
    upper = b >> (4 * s);
    nib   = upper & 24'hF;
    if (blz && s >= 1 && upper == 24'd0) return 7'h7F;
    return enc[nib[3:0]];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_bcd_d = '0; m_bcd_s = '0; m_dpm_d = '0; m_dpm_s = '0;
      m_blz_d = 1'b0; m_blz_s = 1'b0; m_pend = 1'b0; m_t = 0;
      exp_an = 6'h3F; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
    end else begin
      int  slot;
      bit  wrap;
      slot    = (m_t / 4) % 6;
      wrap    = (m_t % 24) == 23;
      exp_an  = 6'h3F ^ 6'(1 << slot);
      exp_seg = model_seg(m_bcd_d, m_blz_d, slot);
      exp_dp  = ~m_dpm_d[slot];
      exp_fd  = wrap;
      if (load && wrap) begin
        m_bcd_d = bcd_in; m_dpm_d = dp_mask; m_blz_d = blank_lz; m_pend = 1'b0;
      end else begin
        if (wrap && m_pend) begin
          m_bcd_d = m_bcd_s; m_dpm_d = m_dpm_s; m_blz_d = m_blz_s; m_pend = 1'b0;
        end
        if (load) begin
          m_bcd_s = bcd_in; m_dpm_s = dp_mask; m_blz_s = blank_lz; m_pend = 1'b1;
        end
      end
      m_t = m_t + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  int last_fd = -1;
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      chk("an", 32'(an), 32'(exp_an));
      chk("seg", 32'(seg), 32'(exp_seg));
      chk("dp", 32'(dp), 32'(exp_dp));
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
      chk("pending", 32'(pending), 32'(m_pend));
      if (rst) last_fd = -1;
      else if (frame_done === 1'b1) begin
        if (last_fd >= 0) chk("fd_period", 32'(cyc - last_fd), 32'd24);
        last_fd = cyc;
      end
    end
  end

  task automatic do_load(input logic [23:0] b, input logic [5:0] m, input logic z);
    bcd_in = b; dp_mask = m; blank_lz = z; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fd();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) found = 1'b1;
    end
    chk("frame_done_seen", 32'(found), 32'd1);
  endtask

  // Called on the negedge where frame_done is high; walks the following frame.
  task automatic check_frame(input string name, input logic [41:0] segs, input logic [5:0] dps);
    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 6; s++) begin
      chk({name, "_an"}, 32'(an), 32'(6'h3F ^ 6'(1 << s)));
      chk({name, "_seg"}, 32'(seg), 32'(segs[s*7 +: 7]));
      chk({name, "_model"}, 32'(exp_seg), 32'(segs[s*7 +: 7]));
      chk({name, "_dp"}, 32'(dp), 32'(dps[s]));
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_an", 32'(an), 32'h3F);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_pending", 32'(pending), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_an", 32'(an), 32'h3E);
    chk("post_rst_seg", 32'(seg), 32'h40);
    chk("post_rst_dp", 32'(dp), 32'd1);

    // Scan: digits 6,5,4,3,2,1 from units up
    do_load(24'h123456, 6'h00, 1'b0);
    wait_fd();
    check_frame("scan", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 6'h3F);

    // Leading-zero blanking on and off
    do_load(24'h000507, 6'h00, 1'b1);
    wait_fd();
    check_frame("blank1", {7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40, 7'h78}, 6'h3F);
    do_load(24'h000507, 6'h00, 1'b0);
    wait_fd();
    check_frame("blank0", {7'h40, 7'h40, 7'h40, 7'h12, 7'h40, 7'h78}, 6'h3F);

    // Tear-free: second load mid-frame must wait for the wrap
    do_load(24'h111111, 6'h00, 1'b0);
    wait_fd();
    while ((m_t % 24) / 4 != 2) @(negedge clk);
    do_load(24'h999999, 6'h00, 1'b0);
    while (m_t % 24 != 23) begin
      chk("tear_pending", 32'(pending), 32'd1);
      chk("tear_seg", 32'(seg), 32'h79);
      @(negedge clk);
    end
    wait_fd();
    check_frame("tear_next", {6{7'h10}}, 6'h3F);

    // Collision: load lands exactly on the wrap cycle
    while (m_t % 24 != 23) @(negedge clk);
    do_load(24'h654321, 6'h00, 1'b0);
    chk("coll_pending", 32'(pending), 32'd0);
    chk("coll_fd", 32'(frame_done), 32'd1);
    check_frame("coll", {7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}, 6'h3F);
    chk("coll_pending_after", 32'(pending), 32'd0);

    // Edge: out-of-range nibble counts as nonzero, dp ignores blanking
    do_load(24'h00000A, 6'h20, 1'b1);
    wait_fd();
    check_frame("edge", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F}, 6'h1F);

    // Asynchronous reset with a pending value
    wait_fd();
    repeat (6) @(negedge clk);
    do_load(24'h777777, 6'h15, 1'b0);
    repeat (5) @(negedge clk);
    chk("prerst_pending", 32'(pending), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_an", 32'(an), 32'h3F);
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_dp", 32'(dp), 32'd1);
    chk("arst_pending", 32'(pending), 32'd0);
    chk("arst_fd", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_an", 32'(an), 32'h3E);
    chk("rel_seg", 32'(seg), 32'h40);
    wait_fd();
    check_frame("rel_zero", {6{7'h40}}, 6'h3F);

    // Random loads checked cycle by cycle against the model
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) begin
        logic [23:0] b;
        b = 24'($urandom()) >> (4 * $urandom_range(0, 6));
        do_load(b, 6'($urandom()), 1'($urandom()));
      end
    end
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
